// File: rtl/operand_collector_pkg.sv
// Operand collector shared types and default sizing.
// Provides per-source/per-entry bundles and the default parameter set.
package operand_collector_pkg;

    localparam int OPC_DATA      = 32;
    localparam int OPC_ROB_DEPTH = 16;
    localparam int OPC_ROB       = $clog2(OPC_ROB_DEPTH);
    localparam int OPC_NSRC      = 2;
    localparam int OPC_NWB       = 2;
    localparam int OPC_DEPTH     = 4;

    typedef struct packed {
        logic                rdy;
        logic [OPC_ROB-1:0]  tag;
        logic [OPC_DATA-1:0] data;
    } OpSrc_t;

    typedef struct packed {
        logic                       valid;
        logic [OPC_ROB-1:0]         rob_id;
        OpSrc_t [OPC_NSRC-1:0]      src;
    } OpEntry_t;

endpackage

// File: rtl/age_matrix_sel.sv
// Age tracking for DEPTH slots plus oldest-requester one-hot select.
// Ports: clk/reset/clear, alloc + alloc_oh (slot being written),
// valid (occupied slots), req (candidates), grant (oldest req).
module age_matrix_sel
    import operand_collector_pkg::*;
#(
    parameter int DEPTH = OPC_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             alloc,
    input  logic [DEPTH-1:0] alloc_oh,
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant
);

    // older_q[i][k] = 1 : slot i is older than slot k.
    // Bits of free slots go stale; they are rewritten on the next
    // allocation of that slot and masked by req meanwhile.
    logic [DEPTH-1:0][DEPTH-1:0] older_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            older_q <= '0;
        end else if (alloc) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (alloc_oh[i])
                        older_q[i][k] <= 1'b0;
                    else if (alloc_oh[k])
                        older_q[i][k] <= valid[i];
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int k = 0; k < DEPTH; k++) begin
            grant[k] = req[k];
            for (int i = 0; i < DEPTH; i++)
                if (req[i] && older_q[i][k])
                    grant[k] = 1'b0;
        end
    end

endmodule

// File: rtl/operand_collector.sv
// Operand buffer: holds issued ops until all sources arrive via
// broadcast, then dispatches the oldest ready entry.
// Ports: in_* allocate side, bc_* snoop channels (active-low
// enables), out_* valid/ready dispatch side, flush/reset clear all.
module operand_collector
    import operand_collector_pkg::*;
#(
    parameter  int DATA      = OPC_DATA,
    parameter  int ROB_DEPTH = OPC_ROB_DEPTH,
    parameter  int NSRC      = OPC_NSRC,
    parameter  int NWB       = OPC_NWB,
    parameter  int DEPTH     = OPC_DEPTH,
    localparam int ROB       = $clog2(ROB_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ROB-1:0]       in_rob_id,
    input  logic [NSRC-1:0]      in_src_e_,
    input  logic [NSRC*ROB-1:0]  in_src_tag,
    input  logic [NSRC*DATA-1:0] in_src_data,
    input  logic [NWB-1:0]       bc_e_,
    input  logic [NWB*ROB-1:0]   bc_rob_id,
    input  logic [NWB*DATA-1:0]  bc_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROB-1:0]       out_rob_id,
    output logic [NSRC*DATA-1:0] out_data
);

    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic            rdy;
        logic [ROB-1:0]  tag;
        logic [DATA-1:0] data;
    } src_t;

    typedef struct packed {
        logic                valid;
        logic [ROB-1:0]      rob_id;
        src_t [NSRC-1:0]     src;
    } entry_t;

    entry_t ent_q [DEPTH];
    entry_t ent_d [DEPTH];

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] grant;
    logic [DEPTH-1:0] alloc_oh;
    logic [IW-1:0]    free_idx;
    logic             alloc;
    logic             issue;

    // Returns {hit, data}; lowest matching channel wins.
    function automatic logic [DATA:0] snoop(
        input logic [ROB-1:0] tag
    );
        snoop = '0;
        for (int c = NWB - 1; c >= 0; c--)
            if (!bc_e_[c] && bc_rob_id[c*ROB +: ROB] == tag)
                snoop = {1'b1, bc_data[c*DATA +: DATA]};
    endfunction

    always_comb begin
        valid = '0;
        ready = '0;
        for (int k = 0; k < DEPTH; k++) begin
            valid[k] = ent_q[k].valid;
            ready[k] = ent_q[k].valid;
            for (int s = 0; s < NSRC; s++)
                ready[k] = ready[k] & ent_q[k].src[s].rdy;
        end
    end

    // Lowest-index free slot.
    always_comb begin
        alloc_oh = '0;
        free_idx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (!valid[k]) begin
                alloc_oh    = '0;
                alloc_oh[k] = 1'b1;
                free_idx    = IW'(k);
            end
        end
    end

    assign in_ready  = !flush && !(&valid);
    assign alloc     = in_valid && in_ready;
    assign out_valid = |ready;
    assign issue     = out_valid && out_ready;

    age_matrix_sel #(
        .DEPTH(DEPTH)
    ) u_age (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .alloc    (alloc),
        .alloc_oh (alloc_oh),
        .valid    (valid),
        .req      (ready),
        .grant    (grant)
    );

    always_comb begin
        logic [DATA:0] h;
        h = '0;
        for (int k = 0; k < DEPTH; k++)
            ent_d[k] = ent_q[k];
        for (int k = 0; k < DEPTH; k++) begin
            for (int s = 0; s < NSRC; s++) begin
                h = snoop(ent_q[k].src[s].tag);
                if (ent_q[k].valid && !ent_q[k].src[s].rdy
                    && h[DATA]) begin
                    ent_d[k].src[s].rdy  = 1'b1;
                    ent_d[k].src[s].data = h[DATA-1:0];
                end
            end
        end
        for (int k = 0; k < DEPTH; k++)
            if (issue && grant[k])
                ent_d[k].valid = 1'b0;
        if (alloc) begin
            ent_d[free_idx].valid  = 1'b1;
            ent_d[free_idx].rob_id = in_rob_id;
            for (int s = 0; s < NSRC; s++) begin
                h = snoop(in_src_tag[s*ROB +: ROB]);
                ent_d[free_idx].src[s].tag =
                    in_src_tag[s*ROB +: ROB];
                if (!in_src_e_[s]) begin
                    ent_d[free_idx].src[s].rdy  = 1'b1;
                    ent_d[free_idx].src[s].data =
                        in_src_data[s*DATA +: DATA];
                end else begin
                    // Catch a broadcast landing in the alloc cycle.
                    ent_d[free_idx].src[s].rdy  = h[DATA];
                    ent_d[free_idx].src[s].data = h[DATA-1:0];
                end
            end
        end
        if (flush)
            for (int k = 0; k < DEPTH; k++)
                ent_d[k].valid = 1'b0;
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (reset)
                ent_q[k] <= '0;
            else
                ent_q[k] <= ent_d[k];
        end
    end

    always_comb begin
        out_rob_id = '0;
        out_data   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (grant[k]) begin
                out_rob_id = out_rob_id | ent_q[k].rob_id;
                for (int s = 0; s < NSRC; s++)
                    out_data[s*DATA +: DATA] =
                        out_data[s*DATA +: DATA]
                        | ent_q[k].src[s].data;
            end
        end
    end

endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector (DATA=32, ROB=4, NSRC=2,
// NWB=2, DEPTH=4): vector table plus hand-written sequences.
module tb_operand_collector;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rob_id;
    logic [1:0]  in_src_e_;
    logic [7:0]  in_src_tag;
    logic [63:0] in_src_data;
    logic [1:0]  bc_e_;
    logic [7:0]  bc_rob_id;
    logic [63:0] bc_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_rob_id;
    logic [63:0] out_data;

    operand_collector dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rob_id   (in_rob_id),
        .in_src_e_   (in_src_e_),
        .in_src_tag  (in_src_tag),
        .in_src_data (in_src_data),
        .bc_e_       (bc_e_),
        .bc_rob_id   (bc_rob_id),
        .bc_data     (bc_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rob_id  (out_rob_id),
        .out_data    (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        fl;
        logic        iv;
        logic [3:0]  rob;
        logic [1:0]  se;
        logic [7:0]  tg;
        logic [63:0] sd;
        logic [1:0]  be;
        logic [7:0]  bt;
        logic [63:0] bd;
        logic        ordy;
        logic        x_inr;
        logic        x_ov;
        logic [3:0]  x_rob;
        logic [63:0] x_data;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];

    function automatic logic [63:0] d2(
        input logic [31:0] hi,
        input logic [31:0] lo
    );
        return {hi, lo};
    endfunction

    function automatic vec_t mk(
        input string n, input logic rst, input logic fl,
        input logic iv, input logic [3:0] rob,
        input logic [1:0] se, input logic [7:0] tg,
        input logic [63:0] sd, input logic [1:0] be,
        input logic [7:0] bt, input logic [63:0] bd,
        input logic ordy, input logic inr, input logic ov,
        input logic [3:0] xr, input logic [63:0] xd
    );
        vec_t v;
        v.name = n; v.rst = rst; v.fl = fl; v.iv = iv;
        v.rob = rob; v.se = se; v.tg = tg; v.sd = sd;
        v.be = be; v.bt = bt; v.bd = bd; v.ordy = ordy;
        v.x_inr = inr; v.x_ov = ov; v.x_rob = xr;
        v.x_data = xd;
        return v;
    endfunction

    // Idle cycle: no alloc, no broadcast, only expectations.
    function automatic vec_t idl(
        input string n, input logic ordy, input logic inr,
        input logic ov, input logic [3:0] xr,
        input logic [63:0] xd
    );
        return mk(n, 0, 0, 0, 4'h0, 2'b11, 8'h00, 64'h0,
                  2'b11, 8'h00, 64'h0, ordy, inr, ov, xr, xd);
    endfunction

    task automatic step(input vec_t v);
        @(negedge clk);
        reset       = v.rst;
        flush       = v.fl;
        in_valid    = v.iv;
        in_rob_id   = v.rob;
        in_src_e_   = v.se;
        in_src_tag  = v.tg;
        in_src_data = v.sd;
        bc_e_       = v.be;
        bc_rob_id   = v.bt;
        bc_data     = v.bd;
        out_ready   = v.ordy;
        #1;
        n_vec++;
        if (in_ready !== v.x_inr || out_valid !== v.x_ov ||
            out_rob_id !== v.x_rob || out_data !== v.x_data) begin
            n_err++;
            $display("FAIL %s: got inr=%b ov=%b rob=%0d data=%h",
                     v.name, in_ready, out_valid, out_rob_id,
                     out_data);
            $display("  required inr=%b ov=%b rob=%0d data=%h",
                     v.x_inr, v.x_ov, v.x_rob, v.x_data);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_rob_id = '0; in_src_e_ = 2'b11; in_src_tag = '0;
        in_src_data = '0; bc_e_ = 2'b11; bc_rob_id = '0;
        bc_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);

        tbl.push_back(idl("rst_state", 0, 1, 0, 0, 0));
        // Ready-at-alloc: one cycle latency, then empty.
        tbl.push_back(mk("a_alloc", 0, 0, 1, 4'd5, 2'b00,
            8'h00, d2(32'h22, 32'h11), 2'b11, 8'h00, 64'h0,
            1, 1, 0, 0, 0));
        tbl.push_back(idl("a_out", 1, 1, 1, 4'd5,
            d2(32'h22, 32'h11)));
        tbl.push_back(idl("a_empty", 1, 1, 0, 0, 0));
        // src0 waits on tag 7, ch1 broadcasts it two cycles on.
        tbl.push_back(mk("b_alloc", 0, 0, 1, 4'd3, 2'b01,
            8'h07, d2(32'h33, 32'h0), 2'b11, 8'h00, 64'h0,
            1, 1, 0, 0, 0));
        tbl.push_back(idl("b_wait", 1, 1, 0, 0, 0));
        tbl.push_back(mk("b_bc", 0, 0, 0, 4'd0, 2'b11,
            8'h00, 64'h0, 2'b00, 8'h78,
            d2(32'hABCD, 32'h1111), 1, 1, 0, 0, 0));
        tbl.push_back(idl("b_out", 1, 1, 1, 4'd3,
            d2(32'h33, 32'hABCD)));
        tbl.push_back(idl("b_empty", 1, 1, 0, 0, 0));
        // Broadcast in the alloc cycle is captured.
        tbl.push_back(mk("c_alloc", 0, 0, 1, 4'd2, 2'b10,
            8'h90, d2(32'h0, 32'h44), 2'b10, 8'h09,
            d2(32'h0, 32'h9999), 1, 1, 0, 0, 0));
        tbl.push_back(idl("c_out", 1, 1, 1, 4'd2,
            d2(32'h9999, 32'h44)));
        tbl.push_back(idl("c_empty", 1, 1, 0, 0, 0));
        // Both channels match: channel 0 data wins.
        tbl.push_back(mk("d_alloc", 0, 0, 1, 4'd6, 2'b01,
            8'h04, d2(32'h66, 32'h0), 2'b11, 8'h00, 64'h0,
            1, 1, 0, 0, 0));
        tbl.push_back(mk("d_bc", 0, 0, 0, 4'd0, 2'b11,
            8'h00, 64'h0, 2'b00, 8'h44,
            d2(32'hBBBB, 32'hAAAA), 1, 1, 0, 0, 0));
        tbl.push_back(idl("d_out", 1, 1, 1, 4'd6,
            d2(32'h66, 32'hAAAA)));
        tbl.push_back(idl("d_empty", 1, 1, 0, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // Fill all slots, wake youngest then oldest.
        for (int r = 8; r < 12; r++)
            step(mk("f_fill", 0, 0, 1, 4'(r), 2'b01,
                {4'h0, 4'(r + 4)}, d2(32'h100 + r, 32'h0),
                2'b11, 8'h00, 64'h0, 0, 1, 0, 0, 0));
        step(mk("f_full", 0, 0, 1, 4'd1, 2'b00, 8'h00,
            d2(32'h1, 32'h1), 2'b10, 8'h0F,
            d2(32'h0, 32'hF15), 0, 0, 0, 0, 0));
        step(mk("f_young", 0, 0, 0, 4'd0, 2'b11, 8'h00,
            64'h0, 2'b10, 8'h0C, d2(32'h0, 32'hF12),
            0, 0, 1, 4'd11, d2(32'h10B, 32'hF15)));
        step(mk("f_oldest", 0, 0, 1, 4'd13, 2'b00, 8'h00,
            d2(32'hD, 32'hD), 2'b11, 8'h00, 64'h0,
            1, 0, 1, 4'd8, d2(32'h108, 32'hF12)));
        step(mk("f_iss_alloc", 0, 0, 1, 4'd12, 2'b00, 8'h00,
            d2(32'h222, 32'h111), 2'b11, 8'h00, 64'h0,
            1, 1, 1, 4'd11, d2(32'h10B, 32'hF15)));
        step(mk("f_new", 0, 0, 0, 4'd0, 2'b11, 8'h00, 64'h0,
            2'b01, 8'hD0, d2(32'hF13, 32'h0),
            0, 1, 1, 4'd12, d2(32'h222, 32'h111)));
        step(idl("f_older", 1, 1, 1, 4'd9,
            d2(32'h109, 32'hF13)));
        step(idl("f_next", 1, 1, 1, 4'd12,
            d2(32'h222, 32'h111)));
        step(mk("f_pend", 0, 0, 0, 4'd0, 2'b11, 8'h00, 64'h0,
            2'b10, 8'h0E, d2(32'h0, 32'hF14),
            0, 1, 0, 0, 0));
        step(idl("f_last", 1, 1, 1, 4'd10,
            d2(32'h10A, 32'hF14)));
        step(idl("f_empty", 1, 1, 0, 0, 0));

        // Reset with three valid entries.
        for (int r = 1; r < 4; r++)
            step(mk("r_fill", 0, 0, 1, 4'(r), 2'b00, 8'h00,
                d2(32'(r), 32'(r)), 2'b11, 8'h00, 64'h0,
                0, 1, r > 1, r > 1 ? 4'd1 : 4'd0,
                r > 1 ? d2(32'h1, 32'h1) : 64'h0));
        step(mk("r_assert", 1, 0, 0, 4'd0, 2'b11, 8'h00,
            64'h0, 2'b11, 8'h00, 64'h0,
            0, 1, 1, 4'd1, d2(32'h1, 32'h1)));
        step(idl("r_after", 1, 1, 0, 0, 0));
        step(idl("r_never", 1, 1, 0, 0, 0));

        // Flush beats alloc and wakeup in the same cycle.
        step(mk("x_a", 0, 0, 1, 4'd4, 2'b00, 8'h00,
            d2(32'h4, 32'h4), 2'b11, 8'h00, 64'h0,
            0, 1, 0, 0, 0));
        step(mk("x_b", 0, 0, 1, 4'd5, 2'b01, 8'h06,
            d2(32'h5, 32'h0), 2'b11, 8'h00, 64'h0,
            0, 1, 1, 4'd4, d2(32'h4, 32'h4)));
        step(mk("x_flush", 0, 1, 1, 4'd7, 2'b00, 8'h00,
            d2(32'h7, 32'h7), 2'b10, 8'h06,
            d2(32'h0, 32'h66), 0, 0, 1, 4'd4,
            d2(32'h4, 32'h4)));
        step(idl("x_after", 1, 1, 0, 0, 0));
        step(idl("x_still", 1, 1, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
